// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_RESULT_CACHE_EN to add a one-entry last-result cache.
module div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        div_flush,
    output logic [31:0] div_result,
    output logic        div_valid,
    output logic        divide_stall
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] prev_result;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;

`ifdef DIV_RESULT_CACHE_EN
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic        sgn_lat;
    logic [31:0] q_res;
    logic [31:0] r_res;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic        c_sgn;
    logic [31:0] c_q;
    logic [31:0] c_r;
    logic        c_valid;
    logic        hit;
`endif

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic [31:0] sp_q;
    logic [31:0] sp_r;
    logic        start;

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] fin_q;
    logic [31:0] fin_r;
    logic        unused_rem_msb;

    assign sgn      = ~div_op[0];
    assign a_neg    = sgn & rs1_val[31];
    assign b_neg    = sgn & rs2_val[31];
    assign a_mag    = a_neg ? -rs1_val : rs1_val;
    assign b_mag    = b_neg ? -rs2_val : rs2_val;
    assign div_zero = (rs2_val == 32'd0);
    assign ovf      = sgn & (rs1_val == 32'h8000_0000)
                    & (rs2_val == 32'hFFFF_FFFF);
    assign special  = div_zero | ovf;
    assign sp_q     = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    assign sp_r     = div_zero ? rs1_val : 32'd0;
    assign start    = div_start & ~div_flush;

`ifdef DIV_RESULT_CACHE_EN
    assign hit = c_valid & (c_a == rs1_val)
               & (c_b == rs2_val) & (c_sgn == sgn);
`endif

    // The remainder never exceeds the divisor, so its MSB stays clear.
    assign unused_rem_msb = rem[32];
    assign rem_sh = {rem[31:0], quo[31]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign rem_nx = diff[32] ? rem_sh : diff;
    assign quo_nx = {quo[30:0], ~diff[32]};
    assign fin_q  = neg_q ? -quo_nx : quo_nx;
    assign fin_r  = neg_r ? -rem_nx[31:0] : rem_nx[31:0];

    assign div_valid    = reset_n & (state == DONE) & ~div_flush;
    assign divide_stall = reset_n & (((state == IDLE) & start)
                        | (state == CALC));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 6'd0;
            rem         <= 33'd0;
            quo         <= 32'd0;
            dvs         <= 32'd0;
            prev_result <= 32'd0;
            div_result  <= 32'd0;
            is_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
            a_lat   <= 32'd0;
            b_lat   <= 32'd0;
            sgn_lat <= 1'b0;
            q_res   <= 32'd0;
            r_res   <= 32'd0;
            c_a     <= 32'd0;
            c_b     <= 32'd0;
            c_sgn   <= 1'b0;
            c_q     <= 32'd0;
            c_r     <= 32'd0;
            c_valid <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_rem <= div_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= 33'd0;
`ifdef DIV_RESULT_CACHE_EN
                        a_lat   <= rs1_val;
                        b_lat   <= rs2_val;
                        sgn_lat <= sgn;
`endif
                        if (special) begin
                            prev_result <= div_result;
                            div_result  <= div_op[1] ? sp_r : sp_q;
                            state       <= DONE;
`ifdef DIV_RESULT_CACHE_EN
                            q_res <= sp_q;
                            r_res <= sp_r;
                        end else if (hit) begin
                            prev_result <= div_result;
                            div_result  <= div_op[1] ? c_r : c_q;
                            q_res       <= c_q;
                            r_res       <= c_r;
                            state       <= DONE;
`endif
                        end else begin
                            cnt   <= 6'd32;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_flush) begin
                        cnt   <= 6'd0;
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            prev_result <= div_result;
                            div_result  <= is_rem ? fin_r : fin_q;
                            state       <= DONE;
`ifdef DIV_RESULT_CACHE_EN
                            q_res <= fin_q;
                            r_res <= fin_r;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    // A killed completion must not leave its result behind.
                    if (div_flush) begin
                        div_result <= prev_result;
                    end
`ifdef DIV_RESULT_CACHE_EN
                    else begin
                        c_a     <= a_lat;
                        c_b     <= b_lat;
                        c_sgn   <= sgn_lat;
                        c_q     <= q_res;
                        c_r     <= r_res;
                        c_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Expected results come from a behavioural divide model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        div_start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        div_flush = 1'b0;
    logic [31:0] div_result;
    logic        div_valid;
    logic        divide_stall;

    typedef struct {
        logic [31:0] res;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    div_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .div_start    (div_start),
        .div_op       (div_op),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .div_flush    (div_flush),
        .div_result   (div_result),
        .div_valid    (div_valid),
        .divide_stall (divide_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int stall_exp);
        exp_t e;
        int   stalls;
        bit   got;
        sb.push_back('{model(op, a, b), stall_exp});
        @(negedge clk);
        div_op    = op;
        rs1_val   = a;
        rs2_val   = b;
        div_start = 1'b1;
        #1;
        stalls = 0;
        got    = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (div_valid) got = 1'b1;
            else begin
                if (divide_stall) stalls++;
                @(negedge clk);
                #1;
            end
        end
        e = sb.pop_front();
        check_eq({tag, "_valid"}, 32'(got), 32'd1);
        check_eq({tag, "_res"}, div_result, e.res);
        check_eq({tag, "_stalls"}, 32'(stalls), 32'(e.stall));
        check_eq({tag, "_stall_done"}, 32'(divide_stall), 32'd0);
        div_start = 1'b0;
    endtask

    logic [31:0] prev;
    int          nvalid;
    int          cache_stall;

    initial begin
`ifdef DIV_RESULT_CACHE_EN
        cache_stall = 1;
`else
        cache_stall = 33;
`endif
        div_start = 1'b1;
        div_op    = 2'b01;
        rs1_val   = 32'd10;
        rs2_val   = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_result", div_result, 32'd0);
        check_eq("rst_valid", 32'(div_valid), 32'd0);
        check_eq("rst_stall", 32'(divide_stall), 32'd0);
        div_start = 1'b0;
        reset_n   = 1'b1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 33);
        run_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 33);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 33);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 1);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1);
        run_op("div_m9_0", 2'b00, -32'sd9, 32'd0, 1);

        // Flush at CALC iteration 10.
        prev = div_result;
        @(negedge clk);
        div_op    = 2'b01;
        rs1_val   = 32'd1000;
        rs2_val   = 32'd3;
        div_start = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_eq("calc_stall", 32'(divide_stall), 32'd1);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        div_start = 1'b0;
        #1;
        check_eq("abort_valid", 32'(div_valid), 32'd0);
        check_eq("abort_stall", 32'(divide_stall), 32'd0);
        check_eq("abort_result", div_result, prev);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 33);

        // Flush in DONE.
        prev = div_result;
        @(negedge clk);
        div_op    = 2'b01;
        rs1_val   = 32'd77;
        rs2_val   = 32'd0;
        div_start = 1'b1;
        @(negedge clk);
        #1;
        div_flush = 1'b1;
        #1;
        check_eq("done_flush_valid", 32'(div_valid), 32'd0);
        @(negedge clk);
        div_flush = 1'b0;
        div_start = 1'b0;
        #1;
        check_eq("done_flush_result", div_result, prev);
        check_eq("done_flush_valid2", 32'(div_valid), 32'd0);

        // Start and flush together block the start.
        @(negedge clk);
        div_op    = 2'b01;
        rs1_val   = 32'd50;
        rs2_val   = 32'd5;
        div_start = 1'b1;
        div_flush = 1'b1;
        #1;
        check_eq("idle_flush_stall", 32'(divide_stall), 32'd0);
        @(negedge clk);
        div_start = 1'b0;
        div_flush = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_valid) nvalid++;
        end
        check_eq("idle_flush_novalid", 32'(nvalid), 32'd0);
        check_eq("idle_flush_result", div_result, prev);

        run_op("div_100_7", 2'b00, 32'd100, 32'd7, 33);
        run_op("rem_100_7", 2'b10, 32'd100, 32'd7, cache_stall);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [1:0]  op;
            a  = $urandom;
            b  = $urandom_range(32'h7FFF, 1) << $urandom_range(16, 0);
            op = 2'($urandom_range(3, 0));
            if (!op[0] && a == 32'h8000_0000) a = 32'd12345;
            run_op($sformatf("rand%0d", k), op, a, b, 33);
        end

        // Reset in CALC discards the op and clears the cache.
        run_op("div_100_7_b", 2'b00, 32'd100, 32'd7, 33);
        @(negedge clk);
        div_op    = 2'b01;
        rs1_val   = 32'd999;
        rs2_val   = 32'd4;
        div_start = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rst_calc_valid", 32'(div_valid), 32'd0);
        @(negedge clk);
        div_start = 1'b0;
        reset_n   = 1'b1;
        #1;
        check_eq("rst_calc_result", div_result, 32'd0);
        check_eq("rst_calc_stall", 32'(divide_stall), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_valid) nvalid++;
        end
        check_eq("rst_calc_novalid", 32'(nvalid), 32'd0);
        run_op("rem_100_7_rst", 2'b10, 32'd100, 32'd7, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
